// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and types for the 640x480@60 Hz raster path.
package vga_timing_pkg;

  // Default 640x480@60 Hz timing (25 MHz pixel clock)
  localparam int unsigned H_VISIBLE_DEF  = 640;
  localparam int unsigned H_FRONT_DEF    = 16;
  localparam int unsigned H_SYNC_DEF     = 96;
  localparam int unsigned H_BACK_DEF     = 48;
  localparam int unsigned V_VISIBLE_DEF  = 480;
  localparam int unsigned V_FRONT_DEF    = 10;
  localparam int unsigned V_SYNC_DEF     = 2;
  localparam int unsigned V_BACK_DEF     = 33;
  localparam int unsigned SYNC_DELAY_DEF = 2;

  // Derived default totals and sync windows (END is exclusive)
  localparam int unsigned H_TOTAL_DEF  = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned V_TOTAL_DEF  = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int unsigned HS_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
  localparam int unsigned VS_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

  // Idle value of {hs, vs, blank}: syncs deasserted (high), blanking
  localparam logic [2:0] SYNC_IDLE = 3'b110;

  // Raster coordinate shared with every renderer consuming DrawX/DrawY
  typedef logic [9:0] coord_t;

  // Half-open window test; 11 bits so an end bound of 1024 still works
  function automatic logic in_window(input logic [10:0] v, input logic [10:0] lo,
                                     input logic [10:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth register pipeline with a synchronous load-to-reset-value.
// DEPTH = 0 degenerates to a combinational pass-through.
module sync_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] rst_val_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    assign q_o = d_i;
    // Clock and reset have no job without any stages
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_i, rst_val_i};
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift pipeline; reset parks every stage on the idle value so fill is glitch-free
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= rst_val_i;
        end
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync and blank generation
// with a configurable alignment delay, plus frame-level pulses for game logic.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT    = H_FRONT_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BACK     = H_BACK_DEF,
  parameter int unsigned V_VISIBLE  = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT    = V_FRONT_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BACK     = V_BACK_DEF,
  parameter int unsigned SYNC_DELAY = SYNC_DELAY_DEF
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_start,
  output logic       vblank_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam coord_t      X_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t      Y_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t      Y_VBLANK = coord_t'(V_VISIBLE);
  localparam logic [10:0] X_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] Y_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_LO    = 11'(HS_START);
  localparam logic [10:0] HS_HI    = 11'(HS_END);
  localparam logic [10:0] VS_LO    = 11'(VS_START);
  localparam logic [10:0] VS_HI    = 11'(VS_END);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (SYNC_DELAY > 7) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY must be in 0..7");
  end

  coord_t     x_q, x_d;
  coord_t     y_q, y_d;
  logic [7:0] fc_q, fc_d;
  logic       hs_raw, vs_raw, blank_raw;
  logic [2:0] sync_in, sync_out;

  // Next raster position; the frame counter bumps on the last pixel of the frame
  always_comb begin
    x_d  = x_q + 10'd1;
    y_d  = y_q;
    fc_d = fc_q;
    if (x_q == X_LAST) begin
      x_d = '0;
      if (y_q == Y_LAST) begin
        y_d  = '0;
        fc_d = fc_q + 8'd1;
      end else begin
        y_d = y_q + 10'd1;
      end
    end
  end

  // Counter registers with synchronous reset
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_q  <= '0;
      y_q  <= '0;
      fc_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      fc_q <= fc_d;
    end
  end

  // Raw sync/blank aligned with the current counters; held idle during reset
  always_comb begin
    hs_raw    = ~in_window({1'b0, x_q}, HS_LO, HS_HI);
    vs_raw    = ~in_window({1'b0, y_q}, VS_LO, VS_HI);
    blank_raw = ({1'b0, x_q} < X_VIS) && ({1'b0, y_q} < Y_VIS);
    sync_in   = reset ? SYNC_IDLE : {hs_raw, vs_raw, blank_raw};
  end

  sync_delay_line #(
    .WIDTH (3),
    .DEPTH (SYNC_DELAY)
  ) u_sync_delay (
    .clk_i     (vga_clk),
    .rst_i     (reset),
    .rst_val_i (SYNC_IDLE),
    .d_i       (sync_in),
    .q_o       (sync_out)
  );

  // Output drive; frame pulses decode the counter registers and are masked by reset
  always_comb begin
    DrawX        = x_q;
    DrawY        = y_q;
    frame_count  = fc_q;
    {hs, vs, blank} = sync_out;
    frame_start  = ~reset && (x_q == '0) && (y_q == '0);
    vblank_start = ~reset && (x_q == '0) && (y_q == Y_VBLANK);
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: dut_a runs default 640x480 timing with SYNC_DELAY=2 for
// line-level checks; dut_b runs a tiny 15x10 raster with SYNC_DELAY=0 so whole
// frames (and the 8-bit frame counter wrap) fit in a short run.
module tb_vga_timing_gen;

  logic       clk;
  logic       reset;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic       a_hs, a_vs, a_blank, a_fs, a_vbs;
  logic       b_hs, b_vs, b_blank, b_fs, b_vbs;
  logic [7:0] a_fc, b_fc;

  int n_cmp;
  int n_err;
  int k;

  vga_timing_gen dut_a (
    .vga_clk      (clk),
    .reset        (reset),
    .DrawX        (a_x),
    .DrawY        (a_y),
    .hs           (a_hs),
    .vs           (a_vs),
    .blank        (a_blank),
    .frame_start  (a_fs),
    .vblank_start (a_vbs),
    .frame_count  (a_fc)
  );

  // B: H 8+2+3+2=15 (hs low x=10..12), V 6+1+2+1=10 (vs low y=7..8), 150 cycles/frame
  vga_timing_gen #(
    .H_VISIBLE  (8),
    .H_FRONT    (2),
    .H_SYNC     (3),
    .H_BACK     (2),
    .V_VISIBLE  (6),
    .V_FRONT    (1),
    .V_SYNC     (2),
    .V_BACK     (1),
    .SYNC_DELAY (0)
  ) dut_b (
    .vga_clk      (clk),
    .reset        (reset),
    .DrawX        (b_x),
    .DrawY        (b_y),
    .hs           (b_hs),
    .vs           (b_vs),
    .blank        (b_blank),
    .frame_start  (b_fs),
    .vblank_start (b_vbs),
    .frame_count  (b_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to absolute cycle index 'target' (k counts negedges since release)
  task automatic adv_to(input int target);
    while (k < target) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int blank_cnt, vs_low, hs_low, vbl_cnt, fs_cnt, a_hs_low;
    n_cmp = 0;
    n_err = 0;
    k     = 0;
    reset = 1'b1;

    // Reset held 5 cycles
    repeat (5) @(negedge clk);
    chk("rst_drawx", a_x, 0);
    chk("rst_drawy", a_y, 0);
    chk("rst_hs", a_hs, 1);
    chk("rst_vs", a_vs, 1);
    chk("rst_blank", a_blank, 0);
    chk("rst_fcount", a_fc, 0);
    chk("rst_fstart", a_fs, 0);
    chk("rst_vbstart", a_vbs, 0);
    chk("rst_b_blank", b_blank, 0);
    chk("rst_b_hs", b_hs, 1);

    // Release: first cycle at (0,0) with frame_start, delay line still idle
    reset = 1'b0;
    #1;
    chk("rel_fstart", a_fs, 1);
    chk("rel_drawx", a_x, 0);
    chk("rel_hs", a_hs, 1);
    chk("rel_blank", a_blank, 0);
    adv_to(1);
    chk("fill1_drawx", a_x, 1);
    chk("fill1_hs", a_hs, 1);
    chk("fill1_vs", a_vs, 1);
    chk("fill1_blank", a_blank, 0);
    chk("fill1_fstart", a_fs, 0);
    adv_to(2);
    chk("fill2_hs", a_hs, 1);
    chk("fill2_blank", a_blank, 1);

    // Line wrap (799,5) -> (0,6)
    adv_to(4799);
    chk("lwrap_x_pre", a_x, 799);
    chk("lwrap_y_pre", a_y, 5);
    adv_to(4800);
    chk("lwrap_x_post", a_x, 0);
    chk("lwrap_y_post", a_y, 6);

    // hsync on line 10 with two-stage delay: low for DrawX 658..753
    adv_to(8657);
    chk("hs_pre_x", a_x, 657);
    chk("hs_pre_y", a_y, 10);
    chk("hs_pre", a_hs, 1);
    adv_to(8658);
    chk("hs_fall", a_hs, 0);
    adv_to(8753);
    chk("hs_last_low", a_hs, 0);
    adv_to(8754);
    chk("hs_rise_x", a_x, 754);
    chk("hs_rise", a_hs, 1);

    // Count hs-low cycles over the whole of line 11
    adv_to(8800);
    a_hs_low = 0;
    for (int i = 0; i < 800; i++) begin
      if (a_hs == 1'b0) a_hs_low++;
      @(negedge clk);
      k++;
    end
    chk("hs_low_count", a_hs_low, 96);

    // k=9600 is exactly 64 small frames
    chk("b_fc64", b_fc, 64);
    chk("b_fs64", b_fs, 1);
    chk("a_line12", a_y, 12);

    // Mid-frame reset: B at (3,4) is in active video
    adv_to(9663);
    chk("mid_b_x", b_x, 3);
    chk("mid_b_y", b_y, 4);
    chk("mid_b_blank", b_blank, 1);
    reset = 1'b1;
    #1;
    chk("mid_b_blank_forced", b_blank, 0);
    chk("mid_b_hs_forced", b_hs, 1);
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    #1;
    chk("mrst_a_x", a_x, 0);
    chk("mrst_a_y", a_y, 0);
    chk("mrst_a_hs", a_hs, 1);
    chk("mrst_a_vs", a_vs, 1);
    chk("mrst_a_blank", a_blank, 0);
    chk("mrst_a_fstart", a_fs, 1);
    chk("mrst_b_x", b_x, 0);
    chk("mrst_b_y", b_y, 0);
    chk("mrst_b_fc", b_fc, 0);

    // One full small frame with point checks at hand-computed cycle indices
    blank_cnt = 0;
    vs_low    = 0;
    hs_low    = 0;
    vbl_cnt   = 0;
    fs_cnt    = 0;
    for (int i = 0; i < 150; i++) begin
      if (b_blank) blank_cnt++;
      if (!b_vs) vs_low++;
      if (!b_hs) hs_low++;
      if (b_vbs) vbl_cnt++;
      if (b_fs) fs_cnt++;
      if (k == 44) begin
        chk("b_lwrap_x_pre", b_x, 14);
        chk("b_lwrap_y_pre", b_y, 2);
      end
      if (k == 45) begin
        chk("b_lwrap_x_post", b_x, 0);
        chk("b_lwrap_y_post", b_y, 3);
      end
      if (k == 82) chk("b_blank_last_act", b_blank, 1);
      if (k == 83) chk("b_blank_hfront", b_blank, 0);
      if (k == 90) begin
        chk("b_blank_vfront", b_blank, 0);
        chk("b_vblank_pulse", b_vbs, 1);
      end
      if (k == 104) chk("b_vs_pre", b_vs, 1);
      if (k == 105) begin
        chk("b_vs_fall", b_vs, 0);
        chk("b_vs_fall_x", b_x, 0);
      end
      if (k == 135) chk("b_vs_rise", b_vs, 1);
      if (k == 149) begin
        chk("b_fwrap_x_pre", b_x, 14);
        chk("b_fwrap_y_pre", b_y, 9);
        chk("b_fwrap_fc_pre", b_fc, 0);
      end
      @(negedge clk);
      k++;
    end
    chk("b_active_count", blank_cnt, 48);
    chk("b_vs_low_count", vs_low, 30);
    chk("b_hs_low_count", hs_low, 30);
    chk("b_vblank_count", vbl_cnt, 1);
    chk("b_fstart_count", fs_cnt, 1);
    chk("b_fwrap_x", b_x, 0);
    chk("b_fwrap_y", b_y, 0);
    chk("b_fwrap_fc", b_fc, 1);
    chk("b_fwrap_fs", b_fs, 1);

    // 256 frames after reset the counter wraps to 0
    adv_to(38399);
    chk("b_fc255", b_fc, 255);
    adv_to(38400);
    chk("b_fc_wrap", b_fc, 0);
    chk("b_fc_wrap_fs", b_fs, 1);
    chk("a_line48", a_y, 48);
    chk("a_fc_still0", a_fc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-timing generator for the 640x480@60 Hz VGA path.
- Produces DrawX/DrawY raster coordinates, hs/vs sync, and the active-video blank qualifier.
- Feeds all per-pixel renderers, including the background ROM stage and sprite layers. Also drives the VGA connector pins.
- Provides a configurable delay on sync/blank so they line up with the registered ROM/palette latency of downstream renderers. Also provides frame-level pulses for game logic.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_DELAY, 2, register stages applied to hs/vs/blank relative to DrawX/DrawY; legal range 0..7

Ports:
- vga_clk, input, 1, pixel clock (25 MHz)
- reset, input, 1, synchronous, active-high
- DrawX, output, 10, horizontal counter; 0..H_TOTAL-1
- DrawY, output, 10, vertical counter; 0..V_TOTAL-1
- hs, output, 1, horizontal sync; active-low; delayed SYNC_DELAY cycles
- vs, output, 1, vertical sync; active-low; delayed SYNC_DELAY cycles
- blank, output, 1, 1 = active video (draw), 0 = blanking; delayed SYNC_DELAY cycles
- frame_start, output, 1, one-cycle pulse while DrawX==0 && DrawY==0; undelayed
- vblank_start, output, 1, one-cycle pulse while DrawX==0 && DrawY==V_VISIBLE; undelayed; safe point for game-state update
- frame_count, output, 8, frames completed since reset; wraps 255->0

Behaviour:
- Totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- Horizontal counter:
  - DrawX increments every vga_clk.
  - At DrawX==H_TOTAL-1 it wraps to 0 next cycle.
- Vertical counter:
  - DrawY increments only on the cycle DrawX wraps.
  - At DrawY==V_TOTAL-1 with the H wrap, it wraps to 0.
- Undelayed raw signals, combinational from the current counters and same-cycle aligned with DrawX/DrawY:
  - hs_raw = 0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vs_raw = 0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491).
  - blank_raw = 1 iff DrawX < H_VISIBLE && DrawY < V_VISIBLE.
- Delay line:
  - hs/vs/blank equal hs_raw/vs_raw/blank_raw from SYNC_DELAY cycles earlier.
  - SYNC_DELAY=0 makes them combinational pass-through of the raw signals.
  - vs window comparisons use DrawY only, so vs edges are coincident with an hs-window-independent DrawX==0 point.
- Reset (synchronous; applies whenever asserted, including mid-line or mid-frame):
  - Next edge sets DrawX=0, DrawY=0, frame_count=0.
  - All delay-line stages are loaded with the inactive value: hs=1, vs=1, blank=0.
  - frame_start and vblank_start are forced 0 while reset is high.
- First cycle after reset release: DrawX=0, DrawY=0, frame_start=1. The delay line then fills with genuine values over SYNC_DELAY cycles; no glitch to hs=0 or vs=0 during fill.
- frame_count increments on the cycle where DrawX==H_TOTAL-1 && DrawY==V_TOTAL-1, i.e. it is visible together with the next frame_start. It wraps silently.
- All outputs except the delayed combinational case (SYNC_DELAY=0) are glitch-free register outputs.
- Widths: counters are 10-bit unsigned. Parameters must satisfy H_TOTAL<=1024 and V_TOTAL<=1024; this is checked with an elaboration-time assertion.

Decomposition:
- Package vga_timing_pkg:
  - the default timing constants above;
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END;
  - typedef coord_t (logic [9:0]), shared with all renderers that consume DrawX/DrawY.
- Sub-module sync_delay_line: parameters WIDTH and DEPTH, with a synchronous reset value port. Instantiated once with WIDTH=3 for {hs,vs,blank} and reset value 3'b110.

Test Plan:
- Reset values: hold reset 5 cycles -> DrawX=0, DrawY=0, hs=1, vs=1, blank=0, frame_count=0, frame_start=0; release -> frame_start=1 on the first cycle, hs stays 1 through the fill.
- hsync window (SYNC_DELAY=2), line 10 -> hs falls on the cycle DrawX=658 and rises on DrawX=754; exactly 96 low cycles per line.
- blank edges (SYNC_DELAY=0) -> blank=1 at (639,479), blank=0 at (640,479) and at (0,480); 640*480=307200 active cycles per frame.
- Line and frame wrap:
  - (799,5) -> (0,6);
  - (799,524) -> (0,0), with frame_count 0->1 and frame_start=1 on the same cycle;
  - 420000 cycles per frame.
- vsync/vblank: vs=0 for exactly 1600 cycles (lines 490-491); vblank_start pulses once per frame at (0,480).
- Reset mid-frame at (300,200) for 1 cycle -> (0,0) next cycle, frame_count=0, hs/vs/blank forced inactive; 256 full frames later frame_count wraps to 0.
